double_clk_rcv: RTL

Receiver for the two-phase open-drain clock pair produced by `double_clk_gen`. It synchronises the `clk0`/`clk1` lines into the local `clk` domain and checks that the phases alternate without overlap. It emits one-cycle phase strobes and a measured period, and flags protocol violations. It sits at the far end of the two-wire link, next to the pull-ups, and feeds the downstream phase-driven logic.

---
 rtl/double_clk_rcv_pkg.sv | 19 +
 rtl/double_clk_rcv_sync2.sv | 27 ++
 rtl/double_clk_rcv.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/double_clk_rcv_pkg.sv
// Shared types for the two-phase clock receiver: FSM state encoding and error causes.
// Pure declarations; no logic, no latency.
package double_clk_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PH0  = 3'd1,
      ST_GAP0 = 3'd2,
      ST_PH1  = 3'd3,
      ST_GAP1 = 3'd4,
      ST_ERR  = 3'd5
   } dcr_state_t;

   localparam logic [1:0] DCR_ERR_NONE    = 2'b00;
   localparam logic [1:0] DCR_ERR_OVERLAP = 2'b01;
   localparam logic [1:0] DCR_ERR_ORDER   = 2'b10;
   localparam logic [1:0] DCR_ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/double_clk_rcv_sync2.sv
// Two-flop synchroniser for one asynchronous line, resetting to RST_VAL.
// Latency 2 edges; no backpressure.
module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/double_clk_rcv.sv
// Receives the clk0/clk1 open-drain phase pair, checks alternation, emits phase strobes and period.
// Latency 3 edges from a settled line change to strobe/error; no backpressure.
module double_clk_rcv
   import double_clk_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clk0,
   input  logic             clk1,
   output logic             ph0_stb,
   output logic             ph1_stb,
   output logic [CNT_W-1:0] period,
   output logic             period_vld,
   output logic             busy,
   output logic             err,
   output logic [1:0]       err_code
);

   localparam int unsigned DW_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [DW_W-1:0]  DWELL_LIM = DW_W'(TIMEOUT);

   logic s0, s1, p0_q, p1_q;
   logic fall0, fall1, rise0, rise1, both_fall, timeout, active;

   dcr_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
   logic [DW_W-1:0]  dwell_q, dwell_d;
   logic             ph0_q, ph0_d, ph1_q, ph1_d, pv_q, pv_d, err_q, err_d;
   logic [1:0]       code_q, code_d, fault;

   sync2 #(.RST_VAL(1'b1)) u_sync0 (.clk_i(clk), .rst_i(rst), .d_i(clk0), .q_o(s0));
   sync2 #(.RST_VAL(1'b1)) u_sync1 (.clk_i(clk), .rst_i(rst), .d_i(clk1), .q_o(s1));

   // Previous-value registers keep running while disabled so edges are never invented on re-enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         p0_q <= 1'b1;
         p1_q <= 1'b1;
      end else begin
         p0_q <= s0;
         p1_q <= s1;
      end
   end

   assign fall0     = ~s0 & p0_q;
   assign fall1     = ~s1 & p1_q;
   assign rise0     = s0 & ~p0_q;
   assign rise1     = s1 & ~p1_q;
   assign both_fall = fall0 & fall1;
   assign timeout   = (dwell_q == DWELL_LIM);
   assign active    = (state_q != ST_IDLE) && (state_q != ST_ERR);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dwell_d  = dwell_q;
      period_d = period_q;
      err_d    = err_q;
      code_d   = code_q;
      ph0_d    = 1'b0;
      ph1_d    = 1'b0;
      pv_d     = 1'b0;
      fault    = DCR_ERR_NONE;

      if (active && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            if (fall0 && !fall1) begin
               state_d = ST_PH0;
               ph0_d   = 1'b1;
            end
         end
         ST_PH0: begin
            if (both_fall || (fall1 && !s0)) fault = DCR_ERR_OVERLAP;
            else if (timeout)                fault = DCR_ERR_TIMEOUT;
            else if (rise0)                  state_d = ST_GAP0;
         end
         ST_GAP0: begin
            if (both_fall)    fault = DCR_ERR_OVERLAP;
            else if (fall0)   fault = DCR_ERR_ORDER;
            else if (timeout) fault = DCR_ERR_TIMEOUT;
            else if (fall1) begin
               state_d = ST_PH1;
               ph1_d   = 1'b1;
            end
         end
         ST_PH1: begin
            if (both_fall || (fall0 && !s1)) fault = DCR_ERR_OVERLAP;
            else if (timeout)                fault = DCR_ERR_TIMEOUT;
            else if (rise1)                  state_d = ST_GAP1;
         end
         ST_GAP1: begin
            if (both_fall)    fault = DCR_ERR_OVERLAP;
            else if (fall1)   fault = DCR_ERR_ORDER;
            else if (timeout) fault = DCR_ERR_TIMEOUT;
            else if (fall0) begin
               state_d  = ST_PH0;
               ph0_d    = 1'b1;
               pv_d     = 1'b1;
               period_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
            end
         end
         ST_ERR: begin
         end
         default: state_d = ST_IDLE;
      endcase

      if (fault != DCR_ERR_NONE) begin
         state_d = ST_ERR;
         err_d   = 1'b1;
         code_d  = fault;
      end

      // Each accepted clk0 fall starts a fresh period measurement.
      if (ph0_d) cnt_d = '0;

      if (state_d != state_q || !active) dwell_d = '0;
      else                               dwell_d = dwell_q + 1'b1;

      if (!en) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         dwell_d  = '0;
         period_d = '0;
         err_d    = 1'b0;
         code_d   = DCR_ERR_NONE;
         ph0_d    = 1'b0;
         ph1_d    = 1'b0;
         pv_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         dwell_q  <= '0;
         period_q <= '0;
         err_q    <= 1'b0;
         code_q   <= DCR_ERR_NONE;
         ph0_q    <= 1'b0;
         ph1_q    <= 1'b0;
         pv_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dwell_q  <= dwell_d;
         period_q <= period_d;
         err_q    <= err_d;
         code_q   <= code_d;
         ph0_q    <= ph0_d;
         ph1_q    <= ph1_d;
         pv_q     <= pv_d;
      end
   end

   assign ph0_stb    = ph0_q;
   assign ph1_stb    = ph1_q;
   assign period_vld = pv_q;
   assign period     = period_q;
   assign err        = err_q;
   assign err_code   = code_q;
   assign busy       = active;

endmodule
